intersection_phase_scheduler: RTL and testbench

Sequences the full phase cycle of the two-road intersection: NS green, NS yellow, all-red, EW green, EW yellow, all-red, repeating. It owns a single shared phase timer and grants an optional WALK phase to two pedestrian request buttons, using round-robin arbitration when both are pending. It sits between the raw button inputs and the lamp drivers. It replaces per-light ad-hoc timers with one configurable down-counter.

---
 rtl/intersection_phase_scheduler.sv | 142 ++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase sequencer with one shared down-counter
// and a round-robin WALK grant for two pedestrian buttons.
module intersection_phase_scheduler #(
    parameter int NBITS        = 32,
    parameter int GREEN_TICKS  = 250000000,
    parameter int YELLOW_TICKS = 75000000,
    parameter int ALLRED_TICKS = 25000000,
    parameter int WALK_TICKS   = 150000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ped_req,
    output logic       ns_green,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       ew_green,
    output logic       ew_yellow,
    output logic       ew_red,
    output logic [1:0] walk,
    output logic [1:0] ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED_A = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        RED_B = 3'd5,
        WALK  = 3'd6
    } state_t;

    localparam logic [NBITS-1:0] LD_G = NBITS'(GREEN_TICKS - 1);
    localparam logic [NBITS-1:0] LD_Y = NBITS'(YELLOW_TICKS - 1);
    localparam logic [NBITS-1:0] LD_R = NBITS'(ALLRED_TICKS - 1);
    localparam logic [NBITS-1:0] LD_W = NBITS'(WALK_TICKS - 1);

    function automatic logic [NBITS-1:0] load_of(input state_t s);
        case (s)
            NS_Y, EW_Y:   load_of = LD_Y;
            RED_A, RED_B: load_of = LD_R;
            WALK:         load_of = LD_W;
            default:      load_of = LD_G;
        endcase
    endfunction

    state_t           state, state_n;
    logic [NBITS-1:0] count, count_n;
    logic [1:0]       pending, pending_n;
    logic [1:0]       prev;
    logic             last_grant, last_n;
    logic             grant, grant_n;
    logic             ret_ew, ret_n;
    logic [1:0]       ack, ack_n;

    logic             done;
    logic [1:0]       grant_oh, cap, win_oh;
    logic             winner;

    assign done     = (count == '0);
    assign grant_oh = grant ? 2'b10 : 2'b01;

    always_comb begin
        // the active walker's own presses are dropped during its WALK
        cap = ped_req & ~prev;
        if (state == WALK) cap = cap & ~grant_oh;

        case (pending)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last_grant;
        endcase
        win_oh = winner ? 2'b10 : 2'b01;

        state_n   = state;
        count_n   = count - NBITS'(1);
        pending_n = pending | cap;
        last_n    = last_grant;
        grant_n   = grant;
        ret_n     = ret_ew;
        ack_n     = 2'b00;

        case (state)
            NS_G: if (done) state_n = NS_Y;
            NS_Y: if (done) state_n = RED_A;
            EW_G: if (done) state_n = EW_Y;
            EW_Y: if (done) state_n = RED_B;
            RED_A, RED_B: begin
                if (done) begin
                    if (|pending) begin
                        state_n   = WALK;
                        ret_n     = (state == RED_A);
                        grant_n   = winner;
                        last_n    = winner;
                        ack_n     = win_oh;
                        pending_n = (pending & ~win_oh) | cap;
                    end else begin
                        state_n = (state == RED_A) ? EW_G : NS_G;
                    end
                end
            end
            WALK: if (done) state_n = ret_ew ? EW_G : NS_G;
            default: state_n = NS_G;
        endcase

        if (done || state_n != state) count_n = load_of(state_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NS_G;
            count      <= LD_G;
            pending    <= 2'b00;
            prev       <= 2'b00;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            ret_ew     <= 1'b1;
            ack        <= 2'b00;
        end else begin
            state      <= state_n;
            count      <= count_n;
            pending    <= pending_n;
            prev       <= ped_req;
            last_grant <= last_n;
            grant      <= grant_n;
            ret_ew     <= ret_n;
            ack        <= ack_n;
        end
    end

    assign ns_green  = (state == NS_G);
    assign ns_yellow = (state == NS_Y);
    assign ns_red    = !(ns_green || ns_yellow);
    assign ew_green  = (state == EW_G);
    assign ew_yellow = (state == EW_Y);
    assign ew_red    = !(ew_green || ew_yellow);
    assign walk      = (state == WALK) ? grant_oh : 2'b00;
    assign ped_ack   = ack;
    assign phase     = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] ped_req = 2'b00;
    logic       ns_green, ns_yellow, ns_red;
    logic       ew_green, ew_yellow, ew_red;
    logic [1:0] walk, ped_ack;
    logic [2:0] phase;

    intersection_phase_scheduler #(
        .NBITS(8), .GREEN_TICKS(10), .YELLOW_TICKS(3),
        .ALLRED_TICKS(2), .WALK_TICKS(6)
    ) dut (
        .clk(clk), .reset(reset), .ped_req(ped_req),
        .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
        .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red),
        .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [1:0] wk;
        logic [1:0] ack;
    } exp_t;

    exp_t sbq[$];
    exp_t plan[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    int   cyc = -1;
    int   scen = 0;

    function automatic logic [12:0] expand(input exp_t e);
        logic [2:0] ns, ew;
        ns = (e.ph == 3'd0) ? 3'b100 : (e.ph == 3'd1) ? 3'b010 : 3'b001;
        ew = (e.ph == 3'd3) ? 3'b100 : (e.ph == 3'd4) ? 3'b010 : 3'b001;
        return {e.ph, ns, ew, e.wk, e.ack};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic [12:0] act;
            exp_t e;
            act = {phase, ns_green, ns_yellow, ns_red,
                   ew_green, ew_yellow, ew_red, walk, ped_ack};
            checks++;
            if (!($onehot({ns_green, ns_yellow, ns_red}) &&
                  $onehot({ew_green, ew_yellow, ew_red}))) begin
                errors++;
                $display("FAIL lamp_onehot scen=%0d cyc=%0d got=%b",
                         scen, cyc, act[7:2]);
            end
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow scen=%0d cyc=%0d", scen, cyc);
            end else begin
                e = sbq.pop_front();
                if (act !== expand(e)) begin
                    errors++;
                    $display("FAIL outputs scen=%0d cyc=%0d got=%b want=%b",
                             scen, cyc, act, expand(e));
                end
            end
        end
    end

    task automatic add(input int ph, input int len, input int wk);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.ph  = 3'(ph);
            e.wk  = 2'(wk);
            e.ack = (i == 0 && ph == 6) ? 2'(wk) : 2'b00;
            plan.push_back(e);
        end
    endtask

    function automatic logic [1:0] ped_at(input int sc, input int c);
        case (sc)
            1: return (c == 3) ? 2'b01 : 2'b00;
            2: return (c == 3) ? 2'b11 : 2'b00;
            3: return ((c >= 2 && c <= 14) || (c >= 17 && c <= 39))
                      ? 2'b10 : 2'b00;
            4: return (c == 14) ? 2'b01 : 2'b00;
            5: return (c == 3) ? 2'b01 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    task automatic build(input int sc);
        plan.delete();
        case (sc)
            0: begin
                add(0,10,0); add(1,3,0); add(2,2,0); add(3,10,0);
                add(4,3,0); add(5,2,0); add(0,10,0); add(1,3,0);
            end
            1: begin
                add(0,10,0); add(1,3,0); add(2,2,0); add(6,6,1);
                add(3,10,0); add(4,3,0); add(5,2,0); add(0,2,0);
            end
            2: begin
                add(0,10,0); add(1,3,0); add(2,2,0); add(6,6,1);
                add(3,10,0); add(4,3,0); add(5,2,0); add(6,6,2);
                add(0,3,0);
            end
            3: begin
                add(0,10,0); add(1,3,0); add(2,2,0); add(6,6,2);
                add(3,10,0); add(4,3,0); add(5,2,0); add(0,4,0);
            end
            4: begin
                add(0,10,0); add(1,3,0); add(2,2,0); add(3,10,0);
                add(4,3,0); add(5,2,0); add(6,6,1); add(0,3,0);
            end
            default: begin
                add(0,10,0); add(1,3,0); add(2,2,0); add(6,3,1);
                add(0,10,0); add(1,3,0); add(2,2,0); add(3,2,0);
            end
        endcase
    endtask

    task automatic run(input int sc);
        exp_t r;
        scen = sc;
        build(sc);
        reset = 1'b1;
        ped_req = 2'b00;
        cyc = -1;
        @(posedge clk); #1;
        r = '0;
        sbq.push_back(r);
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < plan.size(); c++) begin
            cyc = c;
            ped_req = ped_at(sc, c);
            reset = (sc == 5 && c == 17);
            sbq.push_back(plan[c]);
            @(posedge clk); #1;
        end
        mon_en = 1'b0;
        reset = 1'b0;
        ped_req = 2'b00;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover scen=%0d got=%0d want=0",
                     sc, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        for (int s = 0; s < 6; s++) run(s);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
